// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the round-robin bus arbiter that feeds the 32-to-5 bus encoder.
// HOLD_MAX_DEF is used only when the build defines BUS_ARB_TIMEOUT_EN.
package bus_arb_pkg;

    localparam int N_SRC        = 32;
    localparam int IDX_W        = 5;
    localparam int HOLD_MAX_DEF = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } arb_state_e;

    // The input is one-hot, so OR-ing together the indices of all set bits yields the owner index.
    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [N_SRC-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (oh[i]) begin
                idx = idx | IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational wrap-around priority scan: returns the first requester at or above ptr_i,
// wrapping from the top index back to 0.
module rr_pick
    import bus_arb_pkg::*;
(
    input  logic [N_SRC-1:0] req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N_SRC-1:0] pick_o,
    output logic             any_o
);

    logic [IDX_W-1:0] scanIdx;
    logic             found;

    // Index arithmetic is IDX_W bits wide, so the wrap past the top index is free.
    always_comb begin
        pick_o  = '0;
        found   = 1'b0;
        scanIdx = '0;
        for (int i = 0; i < N_SRC; i++) begin
            scanIdx = ptr_i + IDX_W'(i);
            if (!found && req_i[scanIdx]) begin
                pick_o[scanIdx] = 1'b1;
                found           = 1'b1;
            end
        end
    end

    assign any_o = |req_i;

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter issuing a registered one-hot grant and enable to the bus encoder.
// Define BUS_ARB_TIMEOUT_EN to force-release an owner after HOLD_MAX consecutive grant cycles.
module bus_arbiter
    import bus_arb_pkg::*;
`ifdef BUS_ARB_TIMEOUT_EN
#(
    parameter int HOLD_MAX = HOLD_MAX_DEF
)
`endif
(
    input  logic             clk,
    input  logic             clr,
    input  logic [N_SRC-1:0] req,
    input  logic             rel,
    output logic [N_SRC-1:0] grant,
    output logic             bus_en,
    output logic             timeout
);

    arb_state_e       state_q;
    logic [N_SRC-1:0] grant_q;
    logic             busEn_q;
    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;
    logic [IDX_W-1:0] ownerIdx;
    logic [N_SRC-1:0] pick;
    logic             anyReq;
    logic             ownerReq;
    logic             releaseNow;
    logic             holdExpired;
    logic             exitGrant;

    rr_pick u_pick (
        .req_i  (req),
        .ptr_i  (ptr_q),
        .pick_o (pick),
        .any_o  (anyReq)
    );

    // A dropped request from the owner counts as a release.
    assign ownerIdx   = onehot_to_idx(grant_q);
    assign ptr_d      = ownerIdx + IDX_W'(1);
    assign ownerReq   = |(req & grant_q);
    assign releaseNow = rel || !ownerReq;
    assign exitGrant  = releaseNow || holdExpired;

`ifdef BUS_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(HOLD_MAX + 1);

    logic [CNT_W-1:0] holdCnt_q;
    logic [CNT_W-1:0] holdCnt_d;
    logic             timeout_q;

    assign holdExpired = (holdCnt_q == CNT_W'(HOLD_MAX - 1));
    assign holdCnt_d   = (state_q == GRANT) ? holdCnt_q + CNT_W'(1) : '0;

    // The counter idles at zero outside GRANT, so every new ownership starts a fresh count.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            holdCnt_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            holdCnt_q <= holdCnt_d;
            timeout_q <= (state_q == GRANT) && !releaseNow && holdExpired;
        end
    end

    assign timeout = timeout_q;
`else
    assign holdExpired = 1'b0;
    assign timeout     = 1'b0;
`endif

    // TURN always leaves one undriven cycle between owners; IDLE and TURN then pick identically.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= IDLE;
            grant_q <= '0;
            busEn_q <= 1'b0;
            ptr_q   <= '0;
        end else begin
            case (state_q)
                IDLE, TURN: begin
                    if (anyReq) begin
                        state_q <= GRANT;
                        grant_q <= pick;
                        busEn_q <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                        grant_q <= '0;
                        busEn_q <= 1'b0;
                    end
                end
                GRANT: begin
                    if (exitGrant) begin
                        state_q <= TURN;
                        grant_q <= '0;
                        busEn_q <= 1'b0;
                        ptr_q   <= ptr_d;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    grant_q <= '0;
                    busEn_q <= 1'b0;
                end
            endcase
        end
    end

    assign grant  = grant_q;
    assign bus_en = busEn_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: an ownership-level reference model is compared every cycle,
// with directed literal checks for reset, round robin, wrap-around, implicit release and long holds.
module tb_bus_arbiter;
    import bus_arb_pkg::HOLD_MAX_DEF;

`ifdef BUS_ARB_TIMEOUT_EN
    localparam int HoldLimit = HOLD_MAX_DEF;
`else
    localparam int HoldLimit = 0;
`endif

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic [31:0] req = '0;
    logic        rel = 1'b0;
    logic [31:0] grant;
    logic        bus_en;
    logic        timeout;

    int vectors     = 0;
    int miscompares = 0;
    bit checkEn     = 1'b0;

    // Reference model: who owns the bus, where the scan starts, and how long the owner has held it.
    int mOwner   = -1;
    int mPtr     = 0;
    int mHeld    = 0;
    bit mTimeout = 1'b0;

    bus_arbiter dut (
        .clk     (clk),
        .clr     (clr),
        .req     (req),
        .rel     (rel),
        .grant   (grant),
        .bus_en  (bus_en),
        .timeout (timeout)
    );

    initial forever #5 clk = ~clk;

    function automatic int pickFrom(input logic [31:0] r, input int p);
        for (int i = 0; i < 32; i++) begin
            if (r[(p + i) % 32]) return (p + i) % 32;
        end
        return -1;
    endfunction

    function automatic logic [31:0] modelGrant();
        return (mOwner >= 0) ? (32'h1 << mOwner) : 32'h0;
    endfunction

    // Model advances on each active edge, or resets the moment clr rises.
    initial begin
        int  k;
        bit  released;
        forever begin
            @(posedge clk or posedge clr);
            if (clr) begin
                mOwner   = -1;
                mPtr     = 0;
                mHeld    = 0;
                mTimeout = 1'b0;
            end else if (mOwner >= 0) begin
                mHeld++;
                released = rel || !req[mOwner];
                if (released || (HoldLimit != 0 && mHeld == HoldLimit)) begin
                    mTimeout = !released;
                    mPtr     = (mOwner + 1) % 32;
                    mOwner   = -1;
                end
            end else begin
                mTimeout = 1'b0;
                k = pickFrom(req, mPtr);
                if (k >= 0) begin
                    mOwner = k;
                    mHeld  = 0;
                end
            end
        end
    end

    // Every-cycle comparison against the model, plus the bus_en/one-hot invariant.
    initial forever begin
        @(negedge clk);
        if (checkEn) begin
            vectors++;
            if (grant !== modelGrant() || bus_en !== (mOwner >= 0) || timeout !== mTimeout) begin
                miscompares++;
                $display("[TB] FAIL model_cycle t=%0t: grant=%h bus_en=%b timeout=%b, expected grant=%h bus_en=%b timeout=%b",
                         $time, grant, bus_en, timeout, modelGrant(), (mOwner >= 0), mTimeout);
            end
            vectors++;
            if (bus_en !== (|grant) || !$onehot0(grant)) begin
                miscompares++;
                $display("[TB] FAIL invariant t=%0t: grant=%h bus_en=%b, expected one-hot-or-zero grant with bus_en=|grant",
                         $time, grant, bus_en);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [31:0] r, input logic l);
        req = r;
        rel = l;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] expGrant,
                               input logic expEn, input logic expTo);
        vectors++;
        if (grant !== expGrant || bus_en !== expEn || timeout !== expTo) begin
            miscompares++;
            $display("[TB] FAIL %s: grant=%h bus_en=%b timeout=%b, expected grant=%h bus_en=%b timeout=%b",
                     name, grant, bus_en, timeout, expGrant, expEn, expTo);
        end
        vectors++;
        if (modelGrant() !== expGrant || mTimeout !== expTo) begin
            miscompares++;
            $display("[TB] FAIL %s_model: model grant=%h timeout=%b, expected grant=%h timeout=%b",
                     name, modelGrant(), mTimeout, expGrant, expTo);
        end
    endtask

    initial begin
        tick();
        checkOutput("reset_state", 32'h0, 1'b0, 1'b0);
        tick();
        clr     = 1'b0;
        checkEn = 1'b1;

        $display("[TB] single request");
        applyStimulus(32'h0000_0020, 1'b0);
        tick(); checkOutput("single_grant", 32'h20, 1'b1, 1'b0);
        tick();
        tick(); checkOutput("single_hold", 32'h20, 1'b1, 1'b0);
        applyStimulus(32'h0000_0020, 1'b1);
        tick(); checkOutput("single_turn", 32'h0, 1'b0, 1'b0);
        applyStimulus(32'h0000_0020, 1'b0);
        tick(); checkOutput("single_regrant", 32'h20, 1'b1, 1'b0);
        applyStimulus(32'h0, 1'b0);
        tick(); checkOutput("drop_turn", 32'h0, 1'b0, 1'b0);
        tick(); checkOutput("drop_idle", 32'h0, 1'b0, 1'b0);

        $display("[TB] reset mid-transfer");
        applyStimulus(32'h0000_0020, 1'b0);
        tick(); checkOutput("pre_reset_grant", 32'h20, 1'b1, 1'b0);
        #2 clr = 1'b1;
        #1 checkOutput("async_reset", 32'h0, 1'b0, 1'b0);
        tick();
        clr = 1'b0;
        tick(); checkOutput("post_reset_grant", 32'h20, 1'b1, 1'b0);
        applyStimulus(32'h0, 1'b1);
        tick();
        applyStimulus(32'h0, 1'b0);
        tick();
        clr = 1'b1;
        #2 clr = 1'b0;

        $display("[TB] round robin");
        applyStimulus(32'h0000_0088, 1'b0);
        tick(); checkOutput("rr_first", 32'h08, 1'b1, 1'b0);
        applyStimulus(32'h0000_0088, 1'b1);
        tick(); checkOutput("rr_turn1", 32'h0, 1'b0, 1'b0);
        applyStimulus(32'h0000_0088, 1'b0);
        tick(); checkOutput("rr_second", 32'h80, 1'b1, 1'b0);
        applyStimulus(32'h0000_0088, 1'b1);
        tick(); checkOutput("rr_turn2", 32'h0, 1'b0, 1'b0);
        applyStimulus(32'h0000_0088, 1'b0);
        tick(); checkOutput("rr_third", 32'h08, 1'b1, 1'b0);
        applyStimulus(32'h0, 1'b1);
        tick();
        applyStimulus(32'h0, 1'b0);
        tick();

        $display("[TB] wrap-around");
        applyStimulus(32'h8000_0000, 1'b0);
        tick(); checkOutput("wrap_owner31", 32'h8000_0000, 1'b1, 1'b0);
        applyStimulus(32'h8000_0001, 1'b0);
        tick(); checkOutput("wrap_pending_ignored", 32'h8000_0000, 1'b1, 1'b0);
        applyStimulus(32'h8000_0001, 1'b1);
        tick(); checkOutput("wrap_turn", 32'h0, 1'b0, 1'b0);
        applyStimulus(32'h8000_0001, 1'b0);
        tick(); checkOutput("wrap_grant0", 32'h0000_0001, 1'b1, 1'b0);
        applyStimulus(32'h0, 1'b0);
        tick();
        tick();

        $display("[TB] implicit release");
        applyStimulus(32'h0000_0200, 1'b0);
        tick(); checkOutput("implicit_owner", 32'h200, 1'b1, 1'b0);
        applyStimulus(32'h0, 1'b0);
        tick(); checkOutput("implicit_turn", 32'h0, 1'b0, 1'b0);
        tick(); checkOutput("implicit_idle", 32'h0, 1'b0, 1'b0);
        applyStimulus(32'h0000_0600, 1'b0);
        tick(); checkOutput("implicit_ptr10", 32'h400, 1'b1, 1'b0);
        applyStimulus(32'h0, 1'b0);
        tick();
        tick();
        applyStimulus(32'h0, 1'b1);
        tick(); checkOutput("rel_in_idle", 32'h0, 1'b0, 1'b0);

        $display("[TB] long hold");
        applyStimulus(32'h0000_0004, 1'b0);
        tick(); checkOutput("hold_grant", 32'h04, 1'b1, 1'b0);
`ifdef BUS_ARB_TIMEOUT_EN
        for (int i = 1; i < HOLD_MAX_DEF; i++) begin
            tick(); checkOutput("hold_before_timeout", 32'h04, 1'b1, 1'b0);
        end
        tick(); checkOutput("timeout_pulse", 32'h0, 1'b0, 1'b1);
        tick(); checkOutput("timeout_regrant", 32'h04, 1'b1, 1'b0);
`else
        for (int i = 0; i < 100; i++) begin
            tick(); checkOutput("hold_long", 32'h04, 1'b1, 1'b0);
        end
`endif
        applyStimulus(32'h0, 1'b0);
        tick();
        tick();

        $display("[TB] mixed traffic");
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                req = $urandom & $urandom & $urandom;
            end
            rel = ($urandom_range(0, 3) == 0);
            tick();
        end
        applyStimulus(32'h0, 1'b0);
        tick();
        tick();

        checkEn = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Round-robin arbiter directly upstream of the 32-to-5 bus encoder.
- Collects bus-drive requests from up to 32 datapath sources (registers, HI/LO, Z, PC, MDR, in-port, constant).
- Issues a registered one-hot grant, which is the encoder's 32-bit input, plus the encoder's enable.
- Guarantees exactly one or zero bus drivers in every cycle, with a one-cycle turnaround between owners.

Parameters:
- N_SRC, 32, number of request/grant lines; must match the encoder input width.
- HOLD_MAX, 16, maximum consecutive GRANT cycles before forced release; used only with the optional feature.

Ports:
- clk  input  1  system clock, rising edge.
- clr  input  1  asynchronous, active-high reset.
- req  input  N_SRC  per-source request; level, held while the source wants the bus.
- rel  input  1  current owner finished; sampled only in GRANT.
- grant  output  N_SRC  registered one-hot grant; all-zero when no owner; feeds the encoder input.
- bus_en  output  1  registered; high exactly when grant is non-zero; feeds the encoder enable.
- timeout  output  1  one-cycle pulse when an owner is force-released.

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset (clr=1, any time including mid-GRANT): grant=0, bus_en=0, timeout=0, state=IDLE, ptr=0, hold_cnt=0. All outputs take these values immediately, with no clock edge needed.
- States: IDLE, GRANT, TURN. State register, grant, bus_en and timeout are all registered.
- Pick rule (combinational): the first set bit of req scanning upward from ptr, wrapping 31->0. "any" = |req.
- IDLE:
  - If any: next state GRANT, grant <= one-hot of the pick, bus_en <= 1.
  - Else stay in IDLE with outputs 0.
- Latency: req sampled at edge k gives grant/bus_en visible after edge k+1.
- GRANT:
  - grant and bus_en are held constant.
  - Exit to TURN on the first edge where rel=1 OR the owner's req bit is 0. A dropped request counts as an implicit release.
  - On exit: grant <= 0, bus_en <= 0, ptr <= (owner index + 1) mod 32.
- TURN (exactly one dead cycle, bus undriven, encoder tri-stated):
  - Evaluate pick using the updated ptr.
  - If any: GRANT with the new one-hot. Else IDLE.
- Requests from non-owners during GRANT are ignored and stay pending. No queueing beyond the level req lines.
- rel asserted in IDLE or TURN has no effect.
- rel=1 and a new req in the same cycle: release first; the new request competes in TURN.
- Fairness: any continuously asserted req is granted within 31 ownerships.
- grant is never multi-hot. bus_en == |grant at all times; the bench checks this as an assertion.

Optional Feature:
- Macro: BUS_ARB_TIMEOUT_EN.
- Defined:
  - A hold_cnt of width clog2(HOLD_MAX+1) clears on entry to GRANT and increments each GRANT cycle.
  - When hold_cnt reaches HOLD_MAX-1 with no release, the next edge forces TURN and sets timeout=1 for that one cycle.
  - ptr advances as for a normal release.
- Not defined: no counter is synthesised; timeout is tied to 0; an owner may hold the bus indefinitely.

Decomposition:
- Package bus_arb_pkg holds:
  - N_SRC=32 and IDX_W=5.
  - State enum {IDLE, GRANT, TURN}.
  - HOLD_MAX default.
  - Function onehot_to_idx used for the ptr update.
- One sub-module, rr_pick: purely combinational. Inputs req and ptr; outputs one-hot pick and any. This isolates the wrap-around priority scan.

Test Plan:
- Reset mid-transfer: req[5]=1 granted, assert clr between edges -> grant=0 and bus_en=0 immediately; after release of clr with req[5] still high, grant=32'h0000_0020 one edge later.
- Single request: req=32'h0000_0020 at edge 0 -> grant=32'h20 and bus_en=1 after edge 1; rel=1 at edge 3 -> grant=0 after edge 4 (TURN); req still high -> regranted after edge 5.
- Round robin: ptr=0, req bits 3 and 7 held -> grant 32'h08 first; rel -> TURN -> grant 32'h80 (ptr=4); rel -> grant 32'h08 again.
- Wrap-around: owner bit 31, req bits 0 and 31 held, rel -> TURN -> grant 32'h0000_0001 (ptr wrapped to 0).
- Implicit release: owner bit 9 drops req without rel -> TURN the next edge, grant=0, ptr=10; no other req -> IDLE.
- Timeout (BUS_ARB_TIMEOUT_EN, HOLD_MAX=4): req[2] held, rel=0 -> grant 32'h04 for exactly 4 cycles, then timeout=1 for one cycle with grant=0, then regrant. Without the macro: grant is held for 100 cycles and timeout stays 0.
